// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: takes a length-prefixed big-endian byte
// stream and writes 32-bit words to consecutive word addresses from 0.
module im_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  logic [2:0]        state_reg;
  logic [15:0]       len_reg;
  logic [1:0]        byte_idx_reg;
  logic [31:0]       wr_data_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [ADDR_W:0]   words_reg;
  logic              err_reg;

  logic              accept;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   words_inc;
  logic              last_word;

  // in_ready is decoded from the state register only, never from in_valid
  assign in_ready  = (state_reg == S_LEN_HI) || (state_reg == S_LEN_LO) ||
                     (state_reg == S_DATA);
  assign accept    = in_ready && in_valid;
  assign len_full  = {len_reg[15:8], in_data};
  assign words_inc = words_reg + 1'b1;
  assign last_word = (16'(words_inc) == len_reg);

  assign wr_en        = (state_reg == S_WRITE);
  assign busy         = (state_reg == S_LEN_HI) || (state_reg == S_LEN_LO) ||
                        (state_reg == S_DATA)   || (state_reg == S_WRITE);
  assign done         = (state_reg == S_DONE);
  assign err          = err_reg;
  assign wr_addr      = wr_addr_reg;
  assign wr_data      = wr_data_reg;
  assign words_loaded = words_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      len_reg      <= '0;
      byte_idx_reg <= '0;
      wr_data_reg  <= '0;
      wr_addr_reg  <= '0;
      words_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_reg    <= S_LEN_HI;
            err_reg      <= 1'b0;
            words_reg    <= '0;
            wr_addr_reg  <= '0;
            byte_idx_reg <= '0;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_reg[15:8] <= in_data;
            state_reg     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len_reg[7:0] <= in_data;
            if (len_full == 16'd0) begin
              state_reg <= S_DONE;
            end else if ({1'b0, len_full} > DEPTH_L) begin
              // oversize image: flag it and refuse to write anything
              state_reg <= S_DONE;
              err_reg   <= 1'b1;
            end else begin
              state_reg    <= S_DATA;
              byte_idx_reg <= '0;
              wr_addr_reg  <= '0;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            wr_data_reg  <= {wr_data_reg[23:0], in_data};
            byte_idx_reg <= byte_idx_reg + 1'b1;
            if (byte_idx_reg == 2'd3) begin
              state_reg <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          words_reg <= words_inc;
          // the final write leaves wr_addr pointing at the last word written
          if (last_word) begin
            state_reg <= S_DONE;
          end else begin
            wr_addr_reg <= wr_addr_reg + 1'b1;
            state_reg   <= S_DATA;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: drives length-prefixed streams with varied back-pressure
// and compares writes and status against a word-list reference model.
module tb_im_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  im_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          alt_ph = 1'b0;
  wr_t         wr_q[$];
  int          acc_q[$];
  logic [31:0] words[$];

  always @(posedge clk) cyc <= cyc + 1;

  // observe handshakes and write strobes on the falling edge
  always @(negedge clk) begin
    if (in_valid && in_ready) acc_q.push_back(cyc);
    if (wr_en) wr_q.push_back('{addr: int'(wr_addr), data: wr_data, cyc: cyc});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    in_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int mode);
    int t = 0;
    bit got = 1'b0;
    while (!got && t < 100) begin
      @(posedge clk); #1;
      case (mode)
        0: in_valid = 1'b1;
        1: begin alt_ph = ~alt_ph; in_valid = alt_ph; end
        default: in_valid = ($urandom_range(0, 9) < 7);
      endcase
      in_data = in_valid ? b : 8'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) got = 1'b1;
      t++;
    end
    if (!got) chk("send_timeout", 32'(got), 32'd1);
  endtask

  task automatic idle_in();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done !== 1'b1 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("done_wait", 32'(done), 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  // Reference: a valid N (1..DEPTH) writes words[i] to address i, each one
  // cycle after its 4th byte is accepted; an oversize N writes nothing.
  task automatic check_result(input int n, input string tag);
    int exp_w;
    exp_w = (n <= DEPTH) ? n : 0;
    chk({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_w));
    for (int i = 0; i < wr_q.size() && i < exp_w; i++) begin
      chk({tag, "_addr"}, 32'(wr_q[i].addr), 32'(i));
      chk({tag, "_data"}, wr_q[i].data, words[i]);
      if (2 + 4 * i + 3 < acc_q.size())
        chk({tag, "_latency"}, 32'(wr_q[i].cyc), 32'(acc_q[2 + 4 * i + 3] + 1));
    end
    chk({tag, "_accepts"}, 32'(acc_q.size()), 32'(2 + 4 * exp_w));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'(n > DEPTH));
    chk({tag, "_words"}, 32'(words_loaded), 32'(exp_w));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    if (exp_w > 0) chk({tag, "_last_addr"}, 32'(wr_addr), 32'(exp_w - 1));
    $display("load %s: n=%0d writes=%0d done=%0b err=%0b words_loaded=%0d",
             tag, n, wr_q.size(), done, err, words_loaded);
  endtask

  task automatic load_and_check(input int n, input int mode, input bit poke, input string tag);
    logic [15:0] len;
    len = 16'(n);
    wr_q.delete();
    acc_q.delete();
    pulse_start();
    @(negedge clk);
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, "_done_cleared"}, 32'(done), 32'd0);
    send_byte(len[15:8], mode);
    send_byte(len[7:0], mode);
    for (int k = 0; k < words.size(); k++) begin
      for (int b = 3; b >= 0; b--) begin
        send_byte(words[k][8 * b +: 8], mode);
        if (poke && k == 0 && b == 2) pulse_start();
      end
    end
    idle_in();
    if (words.size() == 0) begin
      @(negedge clk);
      chk({tag, "_done_prompt"}, 32'(done), 32'd1);
    end
    wait_done();
    check_result(n, tag);
  endtask

  task automatic fill_random(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    int nz;
    int n;
    // reset then idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    nz = 0;
    repeat (10) begin
      @(negedge clk);
      if (in_ready || wr_en || busy || done || err || words_loaded != 0) nz++;
    end
    chk("idle_activity", 32'(nz), 32'd0);
    check_outputs_zero("idle");
    $display("idle: outputs checked after reset");

    // basic load
    words = '{32'h24080005, 32'h0000000C};
    load_and_check(2, 0, 1'b0, "basic");

    // alternate-cycle back-pressure
    load_and_check(2, 1, 1'b0, "altvalid");

    // length corner cases
    words.delete();
    load_and_check(0, 0, 1'b0, "len0");
    load_and_check(1025, 0, 1'b0, "len1025");
    fill_random(1024);
    load_and_check(1024, 2, 1'b0, "len1024");

    // reset in the middle of a load
    words = '{32'h24080005, 32'h0000000C};
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) send_byte(8'h00, 0);
      else if (i == 1) send_byte(8'h02, 0);
      else send_byte(words[0][8 * (5 - i) +: 8], 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("midrst");
    $display("midrst: outputs checked after reset during load");
    load_and_check(2, 0, 1'b0, "after_rst");

    // start pulse during DATA must be ignored
    words = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
    load_and_check(3, 0, 1'b1, "start_in_data");

    // random short loads with random stalls
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 8);
      fill_random(n);
      load_and_check(n, 2, 1'b0, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
